// File: rtl/bcd_uart_formatter_pkg.sv
// Shared ASCII constants and FSM state encoding for the BCD-to-UART frame formatter.
package bcd_uart_formatter_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] flag_byte(input logic ovf);
    return ovf ? ASCII_PLUS : ASCII_SPACE;
  endfunction

endpackage

// File: rtl/bcd_uart_formatter_bcd_to_ascii.sv
// Combinational BCD digit to ASCII: 0..9 map to '0'..'9', invalid codes to '?'.
module bcd_to_ascii
  import bcd_uart_formatter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  always_comb begin
    if (digit <= 4'd9) ascii = ASCII_ZERO + {4'b0000, digit};
    else               ascii = ASCII_QMARK;
  end

endmodule

// File: rtl/bcd_uart_formatter.sv
// Snapshots a BCD count and streams it as "<flag><digits>\r\n" over a valid/ready byte interface.
module bcd_uart_formatter
  import bcd_uart_formatter_pkg::*;
#(
  parameter int Ndigit = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [Ndigit*4-1:0]   BCD,
  input  logic                  overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int NBYTES = Ndigit + 3;
  localparam int IW     = $clog2(NBYTES);
  localparam logic [IW-1:0] CR_IDX   = IW'(Ndigit + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(Ndigit + 2);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [Ndigit*4-1:0]  bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [IW-1:0]        nxt_idx;
  logic [3:0]           sel_digit;
  logic [7:0]           digit_ascii;
  logic [7:0]           next_byte;

  assign nxt_idx = idx_q + IW'(1);

  // Byte index i in 1..Ndigit carries digit Ndigit-i, so the most significant goes first.
  always_comb begin
    sel_digit = 4'd0;
    for (int k = 0; k < Ndigit; k++) begin
      if (nxt_idx == IW'(Ndigit - k)) sel_digit = bcd_q[4*k +: 4];
    end
  end

  bcd_to_ascii u_bcd_to_ascii (
    .digit (sel_digit),
    .ascii (digit_ascii)
  );

  always_comb begin
    if (nxt_idx == CR_IDX)        next_byte = ASCII_CR;
    else if (nxt_idx == LAST_IDX) next_byte = ASCII_LF;
    else                          next_byte = digit_ascii;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SEND;
          bcd_d      = BCD;
          ovf_d      = overflow;
          idx_d      = '0;
          tx_data_d  = flag_byte(overflow);
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_SEND: begin
        // The following byte is loaded on the same edge as the handshake, allowing back-to-back transfers.
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d    = ST_DONE;
            idx_d      = '0;
            tx_data_d  = 8'h00;
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            idx_d     = nxt_idx;
            tx_data_d = next_byte;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d    = ST_IDLE;
        idx_d      = '0;
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_uart_formatter.sv
// Scoreboard bench: stimulus queues the expected frame bytes, a negedge monitor pops them on each handshake.
module tb_bcd_uart_formatter;

  localparam int NDIG = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [NDIG*4-1:0]   bcd_in = '0;
  logic                overflow = 1'b0;
  logic                tx_ready = 1'b1;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                busy;
  logic                done;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       lf_pending = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       frame_done = 1'b0;
  int         cycles;

  always #5 clk = ~clk;

  bcd_uart_formatter #(.Ndigit(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .BCD      (bcd_in),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one start pulse; when push is set the hand-computed frame is queued for the monitor.
  task automatic applyStimulus(input logic [NDIG*4-1:0] bcd, input logic ovf,
                               input logic [47:0] frame, input bit push);
    @(posedge clk); #2;
    bcd_in   = bcd;
    overflow = ovf;
    start    = 1'b1;
    if (push) for (int i = 0; i < 6; i++) exp_q.push_back(frame[47-8*i -: 8]);
    @(posedge clk); #2;
    start = 1'b0;
    checkOutput("first_valid", {31'b0, tx_valid}, 32'd1);
    checkOutput("first_flag", {24'b0, tx_data}, {24'b0, frame[47:40]});
    checkOutput("busy_in_frame", {31'b0, busy}, 32'd1);
  endtask

  task automatic waitDone(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (done) return;
    end
    checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        checkOutput("stall_valid", {31'b0, tx_valid}, 32'd1);
        checkOutput("stall_data", {24'b0, tx_data}, {24'b0, prev_data});
      end
      if (lf_pending || done) checkOutput("done_pulse", {31'b0, done}, {31'b0, lf_pending});
      lf_pending = 1'b0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_byte: got %0h expected no transfer", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          checkOutput("frame_byte", {24'b0, tx_data}, {24'b0, e});
          if (e == 8'h0A) lf_pending = 1'b1;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
      lf_pending = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("reset_data", {24'b0, tx_data}, 32'h00);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    rst = 1'b1;

    $display("[TB] back-to-back frames");
    applyStimulus(12'h042, 1'b0, 48'h20_30_34_32_0D_0A, 1'b1);
    waitDone(100, cycles);
    checkOutput("cycles_042", cycles, 32'd7);
    applyStimulus(12'h999, 1'b1, 48'h2B_39_39_39_0D_0A, 1'b1);
    waitDone(100, cycles);
    checkOutput("cycles_999", cycles, 32'd7);
    applyStimulus(12'h1C5, 1'b0, 48'h20_31_3F_35_0D_0A, 1'b1);
    waitDone(100, cycles);
    checkOutput("cycles_1C5", cycles, 32'd7);
    applyStimulus(12'hA0F, 1'b1, 48'h2B_3F_30_3F_0D_0A, 1'b1);
    waitDone(100, cycles);
    checkOutput("cycles_A0F", cycles, 32'd7);

    $display("[TB] stalled frame with input changes after capture");
    frame_done = 1'b0;
    applyStimulus(12'h378, 1'b1, 48'h2B_33_37_38_0D_0A, 1'b1);
    bcd_in   = 12'h777;
    overflow = 1'b0;
    fork
      begin
        waitDone(300, cycles);
        frame_done = 1'b1;
      end
      begin
        int stall;
        stall = 2;
        for (int i = 0; i < 400 && !frame_done; i++) begin
          @(posedge clk); #2;
          if (stall > 0) begin
            tx_ready = 1'b0;
            stall--;
          end else begin
            tx_ready = 1'b1;
            stall = $urandom_range(1, 5);
          end
        end
      end
    join
    tx_ready = 1'b1;
    checkOutput("stall_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] start ignored while busy");
    applyStimulus(12'h506, 1'b0, 48'h20_35_30_36_0D_0A, 1'b1);
    @(posedge clk); #2;
    bcd_in   = 12'h999;
    overflow = 1'b1;
    start    = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    waitDone(100, cycles);
    repeat (3) @(negedge clk);
    checkOutput("one_frame_only", exp_q.size(), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(12'h123, 1'b0, 48'h20_31_32_33_0D_0A, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #2;
    checkOutput("abort_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    checkOutput("abort_data", {24'b0, tx_data}, 32'h00);
    checkOutput("abort_remaining", exp_q.size(), 32'd3);
    exp_q.delete();
    start  = 1'b1;
    bcd_in = 12'h555;
    @(posedge clk); #2;
    start = 1'b0;
    checkOutput("reset_priority_valid", {31'b0, tx_valid}, 32'd0);
    checkOutput("reset_priority_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no_done_after_abort", {31'b0, done}, 32'd0);
    end

    applyStimulus(12'h864, 1'b1, 48'h2B_38_36_34_0D_0A, 1'b1);
    waitDone(100, cycles);
    checkOutput("cycles_fresh", cycles, 32'd7);
    repeat (3) @(negedge clk);
    checkOutput("final_queue_empty", exp_q.size(), 32'd0);
    checkOutput("final_idle_busy", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_uart_formatter.md
BCD_UART_FORMATTER -- requirements
Module: bcd_uart_formatter

Interface
REQ-001 Parameter Ndigit, default 3, number of BCD digits in the frame (1..8).
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  one-cycle request to snapshot and transmit the current count.
REQ-005 BCD  input  Ndigit*4  packed BCD count; digit k at BCD[4k+3:4k], digit 0 least significant.
REQ-006 overflow  input  1  counter roll-over flag accompanying BCD.
REQ-007 tx_data  output  8  ASCII byte offered to the UART transmitter.
REQ-008 tx_valid  output  1  tx_data holds a byte to transfer.
REQ-009 tx_ready  input  1  UART transmitter accepts a byte this cycle.
REQ-010 busy  output  1  a frame is in progress.
REQ-011 done  output  1  one-cycle pulse: last byte of the frame has been accepted.

Function
REQ-012 The frame SHALL be, in order: flag byte, Ndigit digit bytes (most significant first), 0x0D, 0x0A; total Ndigit+3 bytes.
REQ-013 Flag byte SHALL be 0x2B ('+') if the snapshot overflow is 1, otherwise 0x20 (space).
REQ-014 Digit byte SHALL be 0x30+d for d in 0..9 and 0x3F ('?') for d in 10..15.
REQ-015 On the cycle start=1 and busy=0, BCD and overflow SHALL be captured into internal registers, and the frame SHALL use only those captured values.
REQ-016 start while busy=1 SHALL be ignored (no queuing, no effect on the current frame).
REQ-017 FSM states: IDLE, SEND, DONE; IDLE->SEND on an accepted start; SEND->SEND per transferred byte while bytes remain; SEND->DONE on transfer of 0x0A; DONE->IDLE unconditionally after one cycle.
REQ-018 tx_valid SHALL rise on the clock edge following an accepted start, with tx_data = flag byte (latency 1 cycle).
REQ-019 A transfer SHALL occur on any edge with tx_valid=1 and tx_ready=1; the next byte SHALL appear on tx_data on that same edge, so back-to-back transfers need no idle cycles.
REQ-020 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL remain unchanged.
REQ-021 tx_valid SHALL be 0 in IDLE and DONE; tx_ready SHALL be ignored when tx_valid=0.
REQ-022 busy SHALL be 1 in SEND and DONE, and 0 in IDLE; done SHALL be 1 only in DONE.
REQ-023 The byte index counter SHALL be ceil(log2(Ndigit+3)) bits wide and SHALL never exceed Ndigit+2.
REQ-024 Changes on BCD and overflow after capture SHALL NOT affect the frame in progress.

Reset
REQ-025 With rst=0 at a rising edge: state=IDLE, tx_valid=0, tx_data=0x00, busy=0, done=0, byte index=0, and captured BCD/overflow cleared to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; no remaining bytes are sent and done is not pulsed.
REQ-027 Reset SHALL take priority over start on the same edge.

Structure
REQ-028 The ASCII constants (0x20, 0x2B, 0x30, 0x3F, 0x0D, 0x0A) and the state encodings SHALL reside in a shared package/include file used by the UART-side blocks.
REQ-029 The digit-to-ASCII mapping SHALL be one combinational sub-module, bcd_to_ascii (4-bit in, 8-bit out), instantiated once and driven by the digit selected by the byte index.

Verification
REQ-030 Ndigit=3, BCD=0x042, overflow=0, start pulse, tx_ready held 1 -> bytes 0x20,0x30,0x34,0x32,0x0D,0x0A on 6 consecutive cycles starting 1 cycle after start; done pulses 1 cycle after 0x0A is accepted.
REQ-031 BCD=0x999, overflow=1 -> frame 0x2B,0x39,0x39,0x39,0x0D,0x0A.
REQ-032 Digit 0xC injected (BCD=0x1C5) -> digit bytes 0x31,0x3F,0x35.
REQ-033 tx_ready randomly deasserted for 1-5 cycles -> tx_data/tx_valid stable during stalls; byte order intact; BCD changed after start does not alter the frame.
REQ-034 start pulsed again mid-frame -> ignored; exactly one frame of Ndigit+3 bytes; new start after done is accepted.
REQ-035 rst=0 after the 3rd byte -> next edge tx_valid=0, busy=0, no done; a subsequent start sends a complete fresh frame.
